// File: rtl/pool_pkg.sv
// Shared definitions for the pool/ReLU frame scheduler: FSM encoding and
// the helpers that derive frame and pooled-frame sizes from the map side W.
package pool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Ceiling log2, used to size counters at elaboration time.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    // Input pixels in one W x W frame (FRAME_PIX).
    function automatic int frame_pix(input int w);
        return w * w;
    endfunction

    // Pooled outputs per channel for a 2x2 pool over a W x W frame (POOL_PIX).
    function automatic int pool_pix(input int w);
        return (w / 2) * (w / 2);
    endfunction

endpackage

// File: rtl/pool_frame_cnt.sv
// Loadable, clearable, saturating up-counter with a terminal-count flag.
// Clear has priority over load, load over increment; the count holds at MAX.
module pool_frame_cnt #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             iClk,
    input  logic             iRsn,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             tc
);

    assign tc = (cnt == WIDTH'(MAX));

    // Count register: clear, load or saturating increment.
    // NOTE: state is written with <= so every flop samples the pre-edge values.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pool_relu_sched.sv
// Frame scheduler for the 4-channel pool/ReLU stage. Gates one W x W frame
// into the wrapper with a 1-cycle registered pixel path, counts pooled
// outputs on the reference channel and reports completion or timeout.
module pool_relu_sched
    import pool_pkg::*;
#(
    parameter  int In_d_W = 32,
    parameter  int W      = 26,
    parameter  int TO_CYC = 64,
    localparam int CNT_W  = clog2(W * W + 1)
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iStart,
    input  logic [3:0]        iChMask,
    input  logic              iInValid,
    output logic              oInReady,
    input  logic [In_d_W-1:0] iInData0,
    input  logic [In_d_W-1:0] iInData1,
    input  logic [In_d_W-1:0] iInData2,
    input  logic [In_d_W-1:0] iInData3,
    output logic [3:0]        oValid4,
    output logic [In_d_W-1:0] oData0,
    output logic [In_d_W-1:0] oData1,
    output logic [In_d_W-1:0] oData2,
    output logic [In_d_W-1:0] oData3,
    input  logic [3:0]        iPrValid4,
    output logic              oBusy,
    output logic              oDone,
    output logic              oErr,
    output logic [CNT_W-1:0]  oOutCnt
);

    localparam int FRAME_PIX = frame_pix(W);
    localparam int POOL_PIX  = pool_pix(W);
    localparam int TO_W      = clog2(TO_CYC + 1);

    state_t           state, state_nxt;
    logic             err_nxt;
    logic [3:0]       mask_q;
    logic [1:0]       ref_idx;
    logic [CNT_W-1:0] in_cnt;
    logic             in_tc, out_tc;
    logic [TO_W-1:0]  to_cnt;
    logic             start_ok, start_go, accept, ref_v;
    logic             in_last, out_hit, to_hit;

    // A start is honoured only in IDLE; an empty mask skips straight to DONE.
    assign start_ok = iStart && (state == IDLE);
    assign start_go = start_ok && (iChMask != 4'd0);

    // Ready follows RUN; it also drops once a full frame has been taken.
    assign oInReady = (state == RUN) && !in_tc;
    assign accept   = iInValid && oInReady;
    assign in_last  = accept && (in_cnt == CNT_W'(FRAME_PIX - 1));

    // Pooled outputs overlap streaming, so they count in RUN and DRAIN only.
    assign ref_v   = iPrValid4[ref_idx] && ((state == RUN) || (state == DRAIN));
    assign out_hit = out_tc || (ref_v && (oOutCnt == CNT_W'(POOL_PIX - 1)));
    assign to_hit  = !ref_v && (to_cnt == TO_W'(TO_CYC - 1));

    assign oBusy = (state != IDLE);
    assign oDone = (state == DONE);

    // Reference channel: lowest set bit of the latched mask.
    // NOTE: every always_comb output gets a default first, so no latch is inferred.
    always_comb begin
        ref_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask_q[i]) ref_idx = 2'(i);
        end
    end

    pool_frame_cnt #(.WIDTH(CNT_W), .MAX(FRAME_PIX)) u_in_cnt (
        .iClk   (iClk),
        .iRsn   (iRsn),
        .clr    (start_go),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (accept),
        .cnt    (in_cnt),
        .tc     (in_tc)
    );

    pool_frame_cnt #(.WIDTH(CNT_W), .MAX(POOL_PIX)) u_out_cnt (
        .iClk   (iClk),
        .iRsn   (iRsn),
        .clr    (start_go),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (ref_v),
        .cnt    (oOutCnt),
        .tc     (out_tc)
    );

    // Next state and completion status.
    always_comb begin
        state_nxt = state;
        err_nxt   = oErr;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    if (iChMask != 4'd0) begin
                        state_nxt = RUN;
                        err_nxt   = 1'b0;
                    end else begin
                        state_nxt = DONE;
                        err_nxt   = 1'b1;
                    end
                end
            end
            RUN: begin
                if (in_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (out_hit) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b0;
                end else if (to_hit) begin
                    state_nxt = DONE;
                    err_nxt   = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and error flag registers.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            state <= IDLE;
            oErr  <= 1'b0;
        end else begin
            state <= state_nxt;
            oErr  <= err_nxt;
        end
    end

    // Channel mask is captured on an accepted non-empty start.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            mask_q <= 4'd0;
        end else if (start_go) begin
            mask_q <= iChMask;
        end
    end

    // Registered pixel path: one-cycle pulse of the mask, data held between beats.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            oValid4 <= 4'd0;
            oData0  <= '0;
            oData1  <= '0;
            oData2  <= '0;
            oData3  <= '0;
        end else begin
            oValid4 <= accept ? mask_q : 4'd0;
            if (accept) begin
                oData0 <= iInData0;
                oData1 <= iInData1;
                oData2 <= iInData2;
                oData3 <= iInData3;
            end
        end
    end

    // Idle-cycle counter in DRAIN, restarted by every reference output.
    always_ff @(posedge iClk) begin
        if (!iRsn) begin
            to_cnt <= '0;
        end else if ((state != DRAIN) || ref_v) begin
            to_cnt <= '0;
        end else if (to_cnt != TO_W'(TO_CYC)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pool_relu_sched.sv
// Bench for pool_relu_sched at W=4 (16 pixels, 4 pooled outputs), TO_CYC=64.
// Registered pixel beats are scored against a queue filled by the driver;
// frame-level behaviour is driven from a table of vectors.
module tb_pool_relu_sched;

    localparam int DW    = 32;
    localparam int WS    = 4;
    localparam int TO    = 64;
    localparam int CW    = 5;
    localparam int FRAME = 16;
    localparam int POOL  = 4;

    logic          iClk     = 1'b0;
    logic          iRsn     = 1'b0;
    logic          iStart   = 1'b0;
    logic [3:0]    iChMask  = 4'd0;
    logic          iInValid = 1'b0;
    logic [DW-1:0] iInData0 = '0;
    logic [DW-1:0] iInData1 = '0;
    logic [DW-1:0] iInData2 = '0;
    logic [DW-1:0] iInData3 = '0;
    logic [3:0]    iPrValid4 = 4'd0;
    logic          oInReady;
    logic [3:0]    oValid4;
    logic [DW-1:0] oData0, oData1, oData2, oData3;
    logic          oBusy, oDone, oErr;
    logic [CW-1:0] oOutCnt;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        int            cyc;
        logic [3:0]    mask;
        logic [DW-1:0] d0, d1, d2, d3;
    } beat_t;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] refb;
        logic [3:0] noise;
        int         gap;
        int         n_run;
        int         n_pool;
        bit         poke;
        logic       exp_err;
        int         exp_cnt;
    } vec_t;

    beat_t sb_q[$];
    beat_t mon_b;
    vec_t  vecs[6];

    pool_relu_sched #(.In_d_W(DW), .W(WS), .TO_CYC(TO)) dut (
        .iClk      (iClk),
        .iRsn      (iRsn),
        .iStart    (iStart),
        .iChMask   (iChMask),
        .iInValid  (iInValid),
        .oInReady  (oInReady),
        .iInData0  (iInData0),
        .iInData1  (iInData1),
        .iInData2  (iInData2),
        .iInData3  (iInData3),
        .oValid4   (oValid4),
        .oData0    (oData0),
        .oData1    (oData1),
        .oData2    (oData2),
        .oData3    (oData3),
        .iPrValid4 (iPrValid4),
        .oBusy     (oBusy),
        .oDone     (oDone),
        .oErr      (oErr),
        .oOutCnt   (oOutCnt)
    );

    always #5 iClk = ~iClk;

    always @(posedge iClk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic string nm(input int idx, input string s);
        return $sformatf("v%0d_%s", idx, s);
    endfunction

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic set_pixel(input int k);
        iInData0 = 32'(k);
        iInData1 = 32'(k) + 32'h100;
        iInData2 = -32'(k);
        iInData3 = 32'hA5A5_0000 ^ 32'(k);
    endtask

    // The beat driven now is expected on the wrapper side one cycle later.
    task automatic push_beat(input logic [3:0] mask);
        beat_t b;
        b.cyc  = cyc + 1;
        b.mask = mask;
        b.d0   = iInData0;
        b.d1   = iInData1;
        b.d2   = iInData2;
        b.d3   = iInData3;
        sb_q.push_back(b);
    endtask

    // Wrapper-side monitor: a beat is due exactly in its scheduled cycle, else no valid.
    always @(negedge iClk) begin
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            mon_b = sb_q.pop_front();
            check("beat_valid", oValid4, mon_b.mask);
            check("beat_d0", oData0, mon_b.d0);
            check("beat_d1", oData1, mon_b.d1);
            check("beat_d2", oData2, mon_b.d2);
            check("beat_d3", oData3, mon_b.d3);
        end else begin
            check("stray_valid", oValid4, 4'd0);
        end
    end

    task automatic run_frame(input vec_t v, input int idx);
        int k;
        int sent;
        int phase;
        int n;
        logic [3:0] pr;
        iStart  = 1'b1;
        iChMask = v.mask;
        tick();
        iStart = 1'b0;
        if (v.mask == 4'd0) begin
            check(nm(idx, "empty_busy"), oBusy, 1'b1);
            check(nm(idx, "empty_done"), oDone, 1'b1);
            check(nm(idx, "empty_err"), oErr, 1'b1);
            check(nm(idx, "empty_ready"), oInReady, 1'b0);
            tick();
            check(nm(idx, "empty_done_end"), oDone, 1'b0);
            check(nm(idx, "empty_busy_end"), oBusy, 1'b0);
            check(nm(idx, "empty_err_hold"), oErr, 1'b1);
            return;
        end
        check(nm(idx, "start_busy"), oBusy, 1'b1);
        check(nm(idx, "start_err_clr"), oErr, 1'b0);
        check(nm(idx, "start_cnt"), oOutCnt, 0);
        k = 0;
        sent = 0;
        phase = 0;
        while (k < FRAME) begin
            iInValid = ((phase % (v.gap + 1)) == 0);
            pr = v.noise;
            if (iInValid && (k == 7 || k == 11) && sent < v.n_run) begin
                pr = pr | v.refb;
                sent++;
            end
            iPrValid4 = pr;
            iStart    = v.poke && (k == 5);
            iChMask   = 4'b1000;
            set_pixel(k);
            check(nm(idx, "run_ready"), oInReady, 1'b1);
            if (iInValid) push_beat(v.mask);
            tick();
            if (iInValid) k++;
            phase++;
            check(nm(idx, "run_cnt"), oOutCnt, sent);
        end
        iInValid = 1'b1;
        iStart   = 1'b0;
        check(nm(idx, "drain_ready"), oInReady, 1'b0);
        check(nm(idx, "drain_busy"), oBusy, 1'b1);
        for (int p = sent; p < v.n_pool; p++) begin
            iPrValid4 = v.noise;
            iStart    = v.poke;
            tick();
            check(nm(idx, "gap_done"), oDone, 1'b0);
            iPrValid4 = v.noise | v.refb;
            iStart    = 1'b0;
            tick();
            check(nm(idx, "drain_cnt"), oOutCnt, p + 1);
            check(nm(idx, "drain_done"), oDone, (p + 1) == POOL);
        end
        if (v.exp_err) begin
            iPrValid4 = v.noise;
            n = 0;
            while (!oDone && n < 200) begin
                tick();
                n++;
            end
            check(nm(idx, "timeout_cycles"), n, TO);
        end
        check(nm(idx, "done"), oDone, 1'b1);
        check(nm(idx, "done_err"), oErr, v.exp_err);
        check(nm(idx, "done_cnt"), oOutCnt, v.exp_cnt);
        iInValid  = 1'b0;
        iPrValid4 = 4'd0;
        tick();
        check(nm(idx, "idle_done"), oDone, 1'b0);
        check(nm(idx, "idle_busy"), oBusy, 1'b0);
        check(nm(idx, "idle_err_hold"), oErr, v.exp_err);
        // Late pooled outputs in IDLE must not move the count.
        iPrValid4 = v.refb;
        tick();
        tick();
        iPrValid4 = 4'd0;
        check(nm(idx, "idle_cnt_hold"), oOutCnt, v.exp_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{mask: 4'b1111, refb: 4'b0001, noise: 4'b0000, gap: 0, n_run: 0, n_pool: 4,
                    poke: 1'b0, exp_err: 1'b0, exp_cnt: 4};
        vecs[1] = '{mask: 4'b0100, refb: 4'b0100, noise: 4'b0001, gap: 1, n_run: 0, n_pool: 4,
                    poke: 1'b0, exp_err: 1'b0, exp_cnt: 4};
        vecs[2] = '{mask: 4'b0000, refb: 4'b0000, noise: 4'b0000, gap: 0, n_run: 0, n_pool: 0,
                    poke: 1'b0, exp_err: 1'b1, exp_cnt: 0};
        vecs[3] = '{mask: 4'b0011, refb: 4'b0001, noise: 4'b0010, gap: 0, n_run: 0, n_pool: 3,
                    poke: 1'b0, exp_err: 1'b1, exp_cnt: 3};
        vecs[4] = '{mask: 4'b1010, refb: 4'b0010, noise: 4'b0101, gap: 2, n_run: 2, n_pool: 4,
                    poke: 1'b0, exp_err: 1'b0, exp_cnt: 4};
        vecs[5] = '{mask: 4'b1111, refb: 4'b0001, noise: 4'b1000, gap: 0, n_run: 2, n_pool: 4,
                    poke: 1'b1, exp_err: 1'b0, exp_cnt: 4};

        // Power-on reset.
        iRsn = 1'b0;
        tick();
        tick();
        check("rst_ready", oInReady, 1'b0);
        check("rst_valid", oValid4, 4'd0);
        check("rst_data0", oData0, 0);
        check("rst_busy", oBusy, 1'b0);
        check("rst_done", oDone, 1'b0);
        check("rst_err", oErr, 1'b0);
        check("rst_cnt", oOutCnt, 0);
        iRsn = 1'b1;
        tick();
        check("idle_ready", oInReady, 1'b0);

        // Reset in the middle of RUN after 7 accepts and one counted output.
        iStart  = 1'b1;
        iChMask = 4'b1111;
        tick();
        iStart = 1'b0;
        for (int k = 0; k < 7; k++) begin
            iInValid  = 1'b1;
            iPrValid4 = (k == 3) ? 4'b0001 : 4'b0000;
            set_pixel(k);
            push_beat(4'b1111);
            tick();
        end
        iInValid  = 1'b0;
        iPrValid4 = 4'd0;
        check("midrst_pre_cnt", oOutCnt, 1);
        iRsn = 1'b0;
        tick();
        iRsn = 1'b1;
        check("midrst_ready", oInReady, 1'b0);
        check("midrst_valid", oValid4, 4'd0);
        check("midrst_data0", oData0, 0);
        check("midrst_data3", oData3, 0);
        check("midrst_busy", oBusy, 1'b0);
        check("midrst_done", oDone, 1'b0);
        check("midrst_err", oErr, 1'b0);
        check("midrst_cnt", oOutCnt, 0);

        for (int i = 0; i < 6; i++) run_frame(vecs[i], i);

        tick();
        check("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
